// File: rtl/cell_link_mux_rr.sv
// N-channel packet-aware stream mux: per-channel FWFT FIFOs feeding one output,
// round-robin arbitration that only switches between channels on TLAST.
module cell_link_mux_rr #(
    parameter  int N_CH  = 2,
    parameter  int DW    = 32,
    parameter  int DEPTH = 40,
    localparam int TW    = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic               ACLK,
    input  logic               ARESET,
    input  logic [N_CH-1:0]    S_AXIS_TVALID,
    input  logic [N_CH*DW-1:0] S_AXIS_TDATA,
    input  logic [N_CH-1:0]    S_AXIS_TLAST,
    output logic [N_CH-1:0]    S_AXIS_TREADY,
    input  logic [N_CH-1:0]    ARB_REQ_SUPPRESS,
    output logic               M_AXIS_TVALID,
    input  logic               M_AXIS_TREADY,
    output logic [DW-1:0]      M_AXIS_TDATA,
    output logic               M_AXIS_TLAST,
    output logic [TW-1:0]      M_AXIS_TID,
    output logic [N_CH-1:0]    OVERFLOW,
    output logic               dbg_busy
);
    // Handshake: a word moves on a port in every cycle where its VALID and READY are both high.
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    typedef enum logic {ST_IDLE = 1'b0, ST_BUSY = 1'b1} state_t;

    state_t        state_q, state_d;
    logic [TW-1:0] grant_q, grant_d, last_q, last_d;

    logic [DW:0]   mem    [N_CH][DEPTH];
    logic [PW-1:0] wr_ptr [N_CH];
    logic [PW-1:0] rd_ptr [N_CH];
    logic [CW-1:0] count  [N_CH];

    logic [N_CH-1:0] push, pop, full, elig_now, elig_pop;
    logic [DW:0]     head;
    logic            pop_last;
    logic [DW-1:0]   hold_data;
    logic            hold_last;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // First requesting channel strictly after base, wrapping; base itself is tried last.
    function automatic logic [TW-1:0] rr_pick(input logic [TW-1:0] base, input logic [N_CH-1:0] req);
        logic [TW-1:0] pick;
        logic          found;
        int            tgt;
        pick  = base;
        found = 1'b0;
        for (int k = 1; k <= N_CH; k++) begin
            tgt = int'(base) + k;
            if (tgt >= N_CH) tgt = tgt - N_CH;
            for (int c = 0; c < N_CH; c++) begin
                if (!found && req[c] && tgt == c) begin
                    pick  = TW'(c);
                    found = 1'b1;
                end
            end
        end
        return pick;
    endfunction

    assign head     = mem[grant_q][rd_ptr[grant_q]];
    assign pop_last = (|pop) & head[DW];

    always_comb begin
        full          = '0;
        S_AXIS_TREADY = '0;
        push          = '0;
        pop           = '0;
        elig_now      = '0;
        elig_pop      = '0;
        for (int c = 0; c < N_CH; c++) begin
            full[c]          = (count[c] == CW'(DEPTH));
            S_AXIS_TREADY[c] = ~full[c] & ~ARESET;
            push[c]          = S_AXIS_TVALID[c] & S_AXIS_TREADY[c];
            pop[c]           = (state_q == ST_BUSY) && (grant_q == TW'(c)) && M_AXIS_TVALID && M_AXIS_TREADY;
            elig_now[c]      = (count[c] != '0) & ~ARB_REQ_SUPPRESS[c];
            // The channel finishing its packet is judged on its occupancy after this pop.
            if (grant_q == TW'(c))
                elig_pop[c] = (count[c] != CW'(1)) & ~ARB_REQ_SUPPRESS[c];
            else
                elig_pop[c] = elig_now[c];
        end
    end

    always_ff @(posedge ACLK) begin
        for (int c = 0; c < N_CH; c++) begin
            if (push[c]) mem[c][wr_ptr[c]] <= {S_AXIS_TLAST[c], S_AXIS_TDATA[c*DW +: DW]};
        end
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            for (int c = 0; c < N_CH; c++) begin
                wr_ptr[c] <= '0;
                rd_ptr[c] <= '0;
                count[c]  <= '0;
            end
            OVERFLOW <= '0;
        end else begin
            for (int c = 0; c < N_CH; c++) begin
                if (push[c]) wr_ptr[c] <= ptr_inc(wr_ptr[c]);
                if (pop[c])  rd_ptr[c] <= ptr_inc(rd_ptr[c]);
                case ({push[c], pop[c]})
                    2'b10:   count[c] <= count[c] + CW'(1);
                    2'b01:   count[c] <= count[c] - CW'(1);
                    default: count[c] <= count[c];
                endcase
                if (S_AXIS_TVALID[c] & full[c]) OVERFLOW[c] <= 1'b1;
            end
        end
    end

    // State register; the hold copy keeps the last shown word visible once the mux goes idle.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state_q   <= ST_IDLE;
            grant_q   <= '0;
            last_q    <= TW'(N_CH - 1);
            hold_data <= '0;
            hold_last <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            if (state_q == ST_BUSY) begin
                hold_data <= head[DW-1:0];
                hold_last <= head[DW];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        case (state_q)
            ST_IDLE: begin
                if (|elig_now) begin
                    grant_d = rr_pick(last_q, elig_now);
                    state_d = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (pop_last) begin
                    last_d = grant_q;
                    if (|elig_pop) grant_d = rr_pick(grant_q, elig_pop);
                    else           state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        dbg_busy   = (state_q == ST_BUSY);
        M_AXIS_TID = grant_q;
        if (state_q == ST_BUSY) begin
            M_AXIS_TVALID = (count[grant_q] != '0);
            M_AXIS_TDATA  = head[DW-1:0];
            M_AXIS_TLAST  = head[DW];
        end else begin
            M_AXIS_TVALID = 1'b0;
            M_AXIS_TDATA  = hold_data;
            M_AXIS_TLAST  = hold_last;
        end
    end
endmodule

// File: tb/tb_cell_link_mux_rr.sv
// Bench for cell_link_mux_rr: queue-level reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
`timescale 1ns/1ps
module tb_cell_link_mux_rr;
    localparam int N     = 4;
    localparam int DW    = 16;
    localparam int DEPTH = 6;
    localparam int TW    = 2;

    logic            ACLK = 1'b0;
    logic            ARESET;
    logic [N-1:0]    s_valid, s_last, s_ready, sup, ovf;
    logic [N*DW-1:0] s_data;
    logic            m_valid, m_ready, m_last, dbg_busy;
    logic [DW-1:0]   m_data;
    logic [TW-1:0]   m_tid;

    cell_link_mux_rr #(.N_CH(N), .DW(DW), .DEPTH(DEPTH)) dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .S_AXIS_TVALID(s_valid), .S_AXIS_TDATA(s_data), .S_AXIS_TLAST(s_last),
        .S_AXIS_TREADY(s_ready), .ARB_REQ_SUPPRESS(sup),
        .M_AXIS_TVALID(m_valid), .M_AXIS_TREADY(m_ready), .M_AXIS_TDATA(m_data),
        .M_AXIS_TLAST(m_last), .M_AXIS_TID(m_tid), .OVERFLOW(ovf), .dbg_busy(dbg_busy)
    );

    always #5 ACLK = ~ACLK;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;
    logic started = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: one queue of {last,data} per channel, plus current owner.
    logic [DW:0]   exp_q [N][$];
    int            owner     = -1;
    int            last_g    = N - 1;
    int            held_tid  = 0;
    logic [DW-1:0] held_data = '0;
    logic          held_last = 1'b0;
    logic [N-1:0]  m_ovf     = '0;

    typedef struct {
        int            cyc;
        int            tid;
        logic          last;
        logic [DW-1:0] data;
    } pop_t;
    pop_t pop_log[$];

    function automatic int find_next(input int base, input logic [N-1:0] avail);
        for (int k = 1; k <= N; k++) begin
            int c = (base + k) % N;
            if (avail[c]) return c;
        end
        return -1;
    endfunction

    function automatic logic model_idle();
        logic empty = 1'b1;
        for (int c = 0; c < N; c++) if (exp_q[c].size() != 0) empty = 1'b0;
        return empty && (owner < 0);
    endfunction

    logic [N-1:0]  e_tready, avail;
    logic          e_valid, e_last, popped;
    logic [DW-1:0] e_data;
    int            e_tid;
    int            pre [N];
    logic [DW:0]   w;
    pop_t          pe;

    always @(negedge ACLK) begin
        cyc++;
        if (started) begin
            for (int c = 0; c < N; c++) e_tready[c] = !ARESET && (exp_q[c].size() < DEPTH);
            if (owner >= 0) begin
                e_tid   = owner;
                e_valid = (exp_q[owner].size() != 0);
                {e_last, e_data} = e_valid ? exp_q[owner][0] : '0;
            end else begin
                e_tid   = held_tid;
                e_valid = 1'b0;
                e_data  = held_data;
                e_last  = held_last;
            end
            chk("s_tready", s_ready, e_tready);
            chk("m_tvalid", m_valid, e_valid);
            chk("m_tid", m_tid, e_tid);
            chk("overflow", ovf, m_ovf);
            if (e_valid || owner < 0) begin
                chk("m_tdata", m_data, e_data);
                chk("m_tlast", m_last, e_last);
            end
            if (m_valid && m_ready && !ARESET) begin
                pe.cyc = cyc; pe.tid = m_tid; pe.last = m_last; pe.data = m_data;
                pop_log.push_back(pe);
            end

            // Advance the model across the coming rising edge.
            if (ARESET) begin
                for (int c = 0; c < N; c++) exp_q[c].delete();
                owner = -1; last_g = N - 1; held_tid = 0;
                held_data = '0; held_last = 1'b0; m_ovf = '0;
            end else begin
                for (int c = 0; c < N; c++) pre[c] = exp_q[c].size();
                popped = 1'b0;
                w      = '0;
                if (owner >= 0 && pre[owner] > 0 && m_ready) begin
                    w = exp_q[owner].pop_front();
                    popped = 1'b1;
                    held_data = w[DW-1:0]; held_last = w[DW]; held_tid = owner;
                end
                for (int c = 0; c < N; c++) begin
                    if (s_valid[c]) begin
                        if (pre[c] < DEPTH) exp_q[c].push_back({s_last[c], s_data[c*DW +: DW]});
                        else m_ovf[c] = 1'b1;
                    end
                end
                for (int c = 0; c < N; c++)
                    avail[c] = ((pre[c] - ((popped && c == owner) ? 1 : 0)) > 0) && !sup[c];
                if (owner < 0) begin
                    owner = find_next(last_g, avail);
                end else if (popped && w[DW]) begin
                    last_g = owner;
                    owner  = find_next(owner, avail);
                end
            end
        end
    end

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    task automatic drain(input string name, input int max);
        m_ready = 1'b1;
        for (int i = 0; i < max; i++) begin
            if (model_idle()) break;
            tick();
        end
        chk(name, model_idle(), 1'b1);
        tick();
    endtask

    int   fair_tid [24] = '{0,0,0,1,1,1,2,2,2,3,3,3,0,0,0,1,1,1,2,2,2,3,3,3};
    int   lock_tid [5]  = '{0,0,0,1,1};
    logic [DW-1:0] lock_dat [5] = '{16'h0A0, 16'h0A1, 16'h0A2, 16'h0B0, 16'h0B1};
    int   sup_tid  [6]  = '{0,0,1,1,0,0};
    logic [DW-1:0] sup_dat [6] = '{16'h0D0, 16'h0D1, 16'h0E0, 16'h0E1, 16'h0D2, 16'h0D3};

    initial begin
        int idx, got;
        logic acc0;
        logic [N-1:0] acc, pending;
        int cnt [N];

        ARESET = 1'b1; s_valid = '0; s_data = '0; s_last = '0; sup = '0; m_ready = 1'b0;
        @(posedge ACLK); #1 started = 1'b1;

        // Reset window and release
        for (int i = 0; i < 3; i++) begin
            @(negedge ACLK);
            chk("rst_tvalid", m_valid, 1'b0);
            chk("rst_tready", s_ready, 4'h0);
        end
        @(posedge ACLK); #1 ARESET = 1'b0;
        @(negedge ACLK);
        chk("post_rst_tready", s_ready, 4'hF);
        chk("post_rst_ovf", ovf, 4'h0);
        chk("post_rst_tid", m_tid, 0);
        chk("post_rst_tdata", m_data, 0);
        tick();

        // Fairness: two 3-word packets per channel, preloaded
        for (int i = 0; i < 6; i++) begin
            s_valid = 4'hF;
            for (int c = 0; c < N; c++) begin
                s_data[c*DW +: DW] = DW'(c * 16 + i);
                s_last[c] = (i % 3 == 2);
            end
            tick();
        end
        s_valid = '0;
        pop_log.delete();
        drain("fair_drain", 80);
        chk("fair_count", pop_log.size(), 24);
        for (int k = 0; k < pop_log.size() && k < 24; k++) begin
            chk("fair_tid", pop_log[k].tid, fair_tid[k]);
            chk("fair_data", pop_log[k].data, fair_tid[k] * 16 + (k / 12) * 3 + k % 3);
            chk("fair_last", pop_log[k].last, (k % 3 == 2));
            chk("fair_nobubble", pop_log[k].cyc - pop_log[0].cyc, k);
        end

        // Packet lock: ch0 stalls mid-packet while ch1 holds a full packet
        pop_log.delete();
        m_ready = 1'b1;
        s_valid = 4'b0011; s_last = 4'b0000;
        s_data[0 +: DW] = 16'h0A0; s_data[DW +: DW] = 16'h0B0;
        tick();
        s_last = 4'b0010;
        s_data[0 +: DW] = 16'h0A1; s_data[DW +: DW] = 16'h0B1;
        tick();
        s_valid = '0;
        tick(); tick();
        for (int i = 0; i < 6; i++) begin
            @(negedge ACLK);
            chk("lock_tvalid", m_valid, 1'b0);
            chk("lock_tid", m_tid, 0);
            tick();
        end
        s_valid = 4'b0001; s_last = 4'b0001; s_data[0 +: DW] = 16'h0A2;
        tick();
        s_valid = '0;
        drain("lock_drain", 40);
        chk("lock_count", pop_log.size(), 5);
        for (int k = 0; k < pop_log.size() && k < 5; k++) begin
            chk("lock_tid_seq", pop_log[k].tid, lock_tid[k]);
            chk("lock_data", pop_log[k].data, lock_dat[k]);
        end
        if (pop_log.size() >= 4) chk("lock_switch_gap", pop_log[3].cyc - pop_log[2].cyc, 1);

        // Full/overflow on ch1 with output stalled
        pop_log.delete();
        m_ready = 1'b0;
        for (int i = 0; i < 7; i++) begin
            s_valid = 4'b0010;
            s_data[DW +: DW] = DW'(16'h0C0 + i);
            s_last = (i >= 5) ? 4'b0010 : 4'b0000;
            @(negedge ACLK);
            if (i == 5) chk("ovf_tready_before_full", s_ready[1], 1'b1);
            if (i == 6) chk("ovf_tready_full", s_ready[1], 1'b0);
            tick();
        end
        s_valid = '0;
        @(negedge ACLK);
        chk("ovf_flag", ovf, 4'b0010);
        tick();
        drain("ovf_drain", 40);
        chk("ovf_count", pop_log.size(), 6);
        for (int k = 0; k < pop_log.size() && k < 6; k++) begin
            chk("ovf_tid", pop_log[k].tid, 1);
            chk("ovf_data", pop_log[k].data, 16'h0C0 + k);
            chk("ovf_last", pop_log[k].last, (k == 5));
        end

        // Suppress ch1..3, then release ch1 during ch0's first packet
        pop_log.delete();
        m_ready = 1'b0;
        sup = 4'b1110;
        for (int i = 0; i < 4; i++) begin
            s_valid = (i < 2) ? 4'b0011 : 4'b0001;
            s_data[0 +: DW]  = DW'(16'h0D0 + i);
            s_data[DW +: DW] = DW'(16'h0E0 + i);
            s_last = (i == 1) ? 4'b0011 : ((i == 3) ? 4'b0001 : 4'b0000);
            tick();
        end
        s_valid = '0;
        m_ready = 1'b1;
        got = 0;
        for (int i = 0; i < 20 && got == 0; i++) begin
            @(negedge ACLK);
            if (m_valid && m_ready) got = 1;
            else tick();
        end
        tick();
        sup = 4'b0000;
        chk("sup_first_pop", got, 1);
        drain("sup_drain", 40);
        chk("sup_count", pop_log.size(), 6);
        for (int k = 0; k < pop_log.size() && k < 6; k++) begin
            chk("sup_tid", pop_log[k].tid, sup_tid[k]);
            chk("sup_data", pop_log[k].data, sup_dat[k]);
        end

        // 100 words on ch0 under random backpressure: pointers wrap many times
        pop_log.delete();
        idx = 0;
        for (int t = 0; t < 3000 && idx < 100; t++) begin
            m_ready = 1'($urandom_range(0, 1));
            s_valid = {3'b000, 1'($urandom_range(0, 3) != 0)};
            s_data[0 +: DW] = DW'(16'h1000 + idx);
            s_last = {3'b000, 1'((idx == 99) || ($urandom_range(0, 4) == 0))};
            @(negedge ACLK);
            acc0 = s_valid[0] & s_ready[0];
            tick();
            if (acc0) idx++;
        end
        s_valid = '0;
        chk("wrap_sent", idx, 100);
        drain("wrap_drain", 200);
        chk("wrap_count", pop_log.size(), 100);
        for (int k = 0; k < pop_log.size() && k < 100; k++)
            chk("wrap_data", pop_log[k].data, 16'h1000 + k);

        // Random traffic on all channels with random suppress and backpressure
        for (int c = 0; c < N; c++) cnt[c] = 0;
        for (int t = 0; t < 400; t++) begin
            if (t % 25 == 0) sup = 4'($urandom_range(0, 15));
            m_ready = 1'($urandom_range(0, 3) != 0);
            for (int c = 0; c < N; c++) begin
                s_valid[c] = ($urandom_range(0, 2) == 0);
                s_data[c*DW +: DW] = DW'(c * 256 + cnt[c]);
                s_last[c] = ($urandom_range(0, 3) == 0);
            end
            @(negedge ACLK);
            acc = s_valid & s_ready;
            tick();
            for (int c = 0; c < N; c++) if (acc[c]) cnt[c]++;
        end
        sup = '0;
        m_ready = 1'b1;
        pending = 4'hF;
        for (int t = 0; t < 200 && pending != 0; t++) begin
            s_valid = pending;
            s_last  = 4'hF;
            for (int c = 0; c < N; c++) s_data[c*DW +: DW] = DW'(c * 256 + 255);
            @(negedge ACLK);
            acc = pending & s_ready;
            tick();
            pending = pending & ~acc;
        end
        s_valid = '0;
        chk("rand_close_sent", pending, 4'h0);
        drain("rand_drain", 400);

        // Reset mid-packet: partial ch2 packet is lost
        m_ready = 1'b1;
        s_valid = 4'b0100; s_last = 4'b0000;
        s_data[2*DW +: DW] = 16'h0F0;
        tick();
        s_data[2*DW +: DW] = 16'h0F1;
        tick();
        s_valid = '0;
        tick();
        ARESET = 1'b1;
        tick(); tick();
        ARESET = 1'b0;
        pop_log.delete();
        @(negedge ACLK);
        chk("rst2_ovf", ovf, 4'h0);
        chk("rst2_tvalid", m_valid, 1'b0);
        tick();
        s_valid = 4'b0100; s_last = 4'b0100; s_data[2*DW +: DW] = 16'h0F5;
        tick();
        s_valid = '0;
        drain("rst2_drain", 40);
        chk("rst2_count", pop_log.size(), 1);
        if (pop_log.size() >= 1) begin
            chk("rst2_tid", pop_log[0].tid, 2);
            chk("rst2_data", pop_log[0].data, 16'h0F5);
            chk("rst2_last", pop_log[0].last, 1'b1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, got t=%0t, required completion earlier", $time);
        n_err++;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
